// File: rtl/ebpf_bitwise_seq.sv
// ebpf_bitwise_seq: sequential bitwise/shift execution unit for the eBPF datapath.
// One ALU op is accepted on the req_* channel and its result is returned on rsp_*.
// OR/AND/XOR and unsupported ops finish in one cycle. Shifts iterate SHIFT_STEP
// bits per cycle, unless EBPF_BITWISE_SEQ_BARREL_EN is defined, in which case a
// single-cycle barrel shifter is used and the SHIFT state is never entered.
// Results are the same in both modes.
module ebpf_bitwise_seq #(
    parameter int SHIFT_STEP = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic        req_alu32,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_data,
    output logic        rsp_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_LSH  = 4'h6;
    localparam logic [3:0] OP_RSH  = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'ha;
    localparam logic [3:0] OP_ARSH = 4'hc;

    localparam logic [6:0] STEP_MAX = 7'(SHIFT_STEP);

    state_t      state_reg, state_next;
    logic [3:0]  op_reg, op_next;
    logic        alu32_reg, alu32_next;
    logic [63:0] work_reg, work_next;
    logic [6:0]  rem_reg, rem_next;
    logic [63:0] data_reg, data_next;
    logic        err_reg, err_next;

    logic [63:0] bit_res;
    logic [63:0] load_work;
    logic [6:0]  load_amt;
    logic [6:0]  step;
    logic [63:0] step_res;

    // Only b[5:0] can ever matter as a shift amount; the rest is ignored on purpose.
    logic unused_b;
    assign unused_b = ^req_b[63:6];

    // Shift val by amt in the direction/fill selected by op (ARSH fills from bit 63).
    function automatic logic [63:0] shift_val(input logic [3:0] op,
                                              input logic [63:0] val,
                                              input logic [6:0] amt);
        logic [63:0] res;
        if (op == OP_LSH)
            res = val << amt;
        else if (op == OP_RSH)
            res = val >> amt;
        else
            res = $signed(val) >>> amt;
        return res;
    endfunction

    // ALU32 results are always zero-extended from bit 31.
    function automatic logic [63:0] finish_val(input logic alu32, input logic [63:0] val);
        return alu32 ? {32'h0, val[31:0]} : val;
    endfunction

    // Outputs are decoded from state or taken straight from registers.
    assign req_ready = (state_reg == IDLE);
    assign rsp_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign rsp_data  = data_reg;
    assign rsp_err   = err_reg;

    // Operand preparation for an incoming request: bitwise result, shift load value and amount.
    always_comb begin
        bit_res   = 64'h0;
        load_work = req_a;
        load_amt  = req_alu32 ? {2'b00, req_b[4:0]} : {1'b0, req_b[5:0]};
        case (req_op)
            OP_OR:   bit_res = req_a | req_b;
            OP_AND:  bit_res = req_a & req_b;
            OP_XOR:  bit_res = req_a ^ req_b;
            default: bit_res = 64'h0;
        endcase
        if (req_alu32) begin
            // ARSH needs the 32-bit sign replicated so bit 63 carries the fill value.
            if (req_op == OP_ARSH)
                load_work = {{32{req_a[31]}}, req_a[31:0]};
            else
                load_work = {32'h0, req_a[31:0]};
        end
    end

    // One iteration step: shift by min(SHIFT_STEP, remaining).
    always_comb begin
        step     = (rem_reg > STEP_MAX) ? STEP_MAX : rem_reg;
        step_res = shift_val(op_reg, work_reg, step);
    end

    // Next-state and next-register logic for the IDLE/SHIFT/DONE sequencer.
    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        alu32_next = alu32_reg;
        work_next  = work_reg;
        rem_next   = rem_reg;
        data_next  = data_reg;
        err_next   = err_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    op_next    = req_op;
                    alu32_next = req_alu32;
                    err_next   = 1'b0;
                    case (req_op)
                        OP_OR, OP_AND, OP_XOR: begin
                            data_next  = finish_val(req_alu32, bit_res);
                            state_next = DONE;
                        end
                        OP_LSH, OP_RSH, OP_ARSH: begin
                            work_next = load_work;
`ifdef EBPF_BITWISE_SEQ_BARREL_EN
                            rem_next   = 7'd0;
                            data_next  = finish_val(req_alu32, shift_val(req_op, load_work, load_amt));
                            state_next = DONE;
`else
                            rem_next = load_amt;
                            if (load_amt == 7'd0) begin
                                data_next  = finish_val(req_alu32, load_work);
                                state_next = DONE;
                            end else begin
                                state_next = SHIFT;
                            end
`endif
                        end
                        default: begin
                            data_next  = 64'h0;
                            err_next   = 1'b1;
                            state_next = DONE;
                        end
                    endcase
                end
            end
            SHIFT: begin
                work_next = step_res;
                rem_next  = rem_reg - step;
                if (rem_reg == step) begin
                    data_next  = finish_val(alu32_reg, step_res);
                    state_next = DONE;
                end
            end
            DONE: begin
                if (rsp_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State and datapath registers; asynchronous reset discards any in-flight op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            op_reg    <= 4'h0;
            alu32_reg <= 1'b0;
            work_reg  <= 64'h0;
            rem_reg   <= 7'd0;
            data_reg  <= 64'h0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            alu32_reg <= alu32_next;
            work_reg  <= work_next;
            rem_reg   <= rem_next;
            data_reg  <= data_next;
            err_reg   <= err_next;
        end
    end

endmodule

// File: tb/tb_ebpf_bitwise_seq.sv
// Directed testbench for ebpf_bitwise_seq with hand-computed expected values.
// Expected latencies follow EBPF_BITWISE_SEQ_BARREL_EN when it is defined.
module tb_ebpf_bitwise_seq;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic        req_alu32;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic        rsp_err;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    ebpf_bitwise_seq #(.SHIFT_STEP(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_alu32 (req_alu32),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycles from the accepting edge to rsp_valid for a shift of n bits, step 8.
    function automatic int shift_lat(input int n);
`ifdef EBPF_BITWISE_SEQ_BARREL_EN
        return 1;
`else
        return (n == 0) ? 1 : 1 + (n + 7) / 8;
`endif
    endfunction

    // Present one request, count edges to rsp_valid, check result, then drain it.
    task automatic run_op(input string tag, input logic [3:0] op, input logic alu32,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_data, input logic exp_err, input int exp_lat);
        int cyc;
        req_op    = op;
        req_alu32 = alu32;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        req_a     = 64'h0;
        req_b     = 64'h0;
        cyc = 1;
        while (!rsp_valid && cyc < 100) begin
            tick();
            cyc++;
        end
        chk({tag, " latency"}, 64'(cyc), 64'(exp_lat));
        chk({tag, " data"}, rsp_data, exp_data);
        chk({tag, " err"}, {63'h0, rsp_err}, {63'h0, exp_err});
        $display("op %h alu32 %0d a %h b %h -> data %h err %0d after %0d cycles",
                 op, alu32, a, b, rsp_data, rsp_err, cyc);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, " req_ready after rsp"}, {63'h0, req_ready}, 64'h1);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 4'h0;
        req_alu32 = 1'b0;
        req_a     = 64'h0;
        req_b     = 64'h0;
        rsp_ready = 1'b0;
        #23;
        chk("reset req_ready", {63'h0, req_ready}, 64'h1);
        chk("reset rsp_valid", {63'h0, rsp_valid}, 64'h0);
        chk("reset rsp_data", rsp_data, 64'h0);
        chk("reset rsp_err", {63'h0, rsp_err}, 64'h0);
        chk("reset busy", {63'h0, busy}, 64'h0);
        rst_n = 1'b1;
        tick();

        run_op("or64", 4'h4, 1'b0, 64'hF0F0_0000_0000_00FF, 64'h0F00_0000_0000_FF00,
               64'hFFF0_0000_0000_FFFF, 1'b0, 1);
        run_op("or32", 4'h4, 1'b1, 64'hF0F0_0000_0000_00FF, 64'h0F00_0000_0000_FF00,
               64'h0000_0000_0000_FFFF, 1'b0, 1);
        run_op("and64", 4'h5, 1'b0, 64'hFF00_FF00_FF00_FF00, 64'h0FF0_0FF0_0FF0_0FF0,
               64'h0F00_0F00_0F00_0F00, 1'b0, 1);
        run_op("xor32", 4'ha, 1'b1, 64'hFFFF_FFFF_AAAA_AAAA, 64'h1234_5678_5555_5555,
               64'h0000_0000_FFFF_FFFF, 1'b0, 1);
        run_op("arsh64 63", 4'hc, 1'b0, 64'h8000_0000_0000_0000, 64'd63,
               64'hFFFF_FFFF_FFFF_FFFF, 1'b0, shift_lat(63));
        run_op("arsh32 4", 4'hc, 1'b1, 64'h0000_0000_8000_0000, 64'd4,
               64'h0000_0000_F800_0000, 1'b0, shift_lat(4));
        run_op("arsh64 pos", 4'hc, 1'b0, 64'h4000_0000_0000_0000, 64'd62,
               64'h0000_0000_0000_0001, 1'b0, shift_lat(62));
        run_op("lsh32 mask", 4'h6, 1'b1, 64'h0000_0000_0000_0001, 64'h25,
               64'h0000_0000_0000_0020, 1'b0, shift_lat(5));
        run_op("lsh64 zero", 4'h6, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0,
               64'h1234_5678_9ABC_DEF0, 1'b0, 1);
        run_op("lsh64 mask", 4'h6, 1'b0, 64'h0000_0000_0000_00FF, 64'h44,
               64'h0000_0000_0000_0FF0, 1'b0, shift_lat(4));
        run_op("rsh64 12", 4'h7, 1'b0, 64'h8000_0000_0000_0000, 64'd12,
               64'h0008_0000_0000_0000, 1'b0, shift_lat(12));
        run_op("rsh32 31", 4'h7, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd31,
               64'h0000_0000_0000_0001, 1'b0, shift_lat(31));

        // Unsupported op with 10 cycles of backpressure.
        req_op    = 4'h9;
        req_alu32 = 1'b0;
        req_a     = 64'hDEAD_BEEF_0000_1111;
        req_b     = 64'h1;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("bad op rsp_valid", {63'h0, rsp_valid}, 64'h1);
        chk("bad op err", {63'h0, rsp_err}, 64'h1);
        chk("bad op data", rsp_data, 64'h0);
        $display("op 9 -> data %h err %0d", rsp_data, rsp_err);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold rsp_valid", {63'h0, rsp_valid}, 64'h1);
            chk("hold err", {63'h0, rsp_err}, 64'h1);
            chk("hold data", rsp_data, 64'h0);
            chk("hold req_ready", {63'h0, req_ready}, 64'h0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("release req_ready", {63'h0, req_ready}, 64'h1);
        chk("release rsp_valid", {63'h0, rsp_valid}, 64'h0);
        chk("release busy", {63'h0, busy}, 64'h0);

        // RSH by 40, then an asynchronous reset while the op is in flight.
        req_op    = 4'h7;
        req_alu32 = 1'b0;
        req_a     = 64'hFFFF_0000_FFFF_0000;
        req_b     = 64'd40;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("rsh40 req_ready busy", {63'h0, req_ready}, 64'h0);
        tick();
`ifndef EBPF_BITWISE_SEQ_BARREL_EN
        chk("rsh40 in shift", {62'h0, rsp_valid, busy}, 64'h1);
`endif
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid reset req_ready", {63'h0, req_ready}, 64'h1);
        chk("mid reset rsp_valid", {63'h0, rsp_valid}, 64'h0);
        chk("mid reset busy", {63'h0, busy}, 64'h0);
        chk("mid reset data", rsp_data, 64'h0);
        chk("mid reset err", {63'h0, rsp_err}, 64'h0);
        #10;
        rst_n = 1'b1;
        $display("reset during rsh 40: busy %0d rsp_valid %0d", busy, rsp_valid);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("no rsp after reset", {62'h0, rsp_valid, busy}, 64'h0);
        end

        // The unit must still work normally afterwards.
        run_op("xor64 after reset", 4'ha, 1'b0, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_0000_0000,
               64'hFEDC_BA98_89AB_CDEF, 1'b0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
